// File: rtl/rr_arbiter16_pkg.sv
// Shared constants and state encoding for the 16-way round-robin arbiter.
package rr_arbiter16_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter16_if.sv
// Requester-to-arbiter bundle: request vector in, grant index and one-hot out.
interface rr_arbiter16_if;
  import rr_arbiter16_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_id;
  logic [NUM_REQ-1:0] gnt;

  // Requester side drives req and observes the grant.
  modport master (output req, input gnt_valid, input gnt_id, input gnt);

  // Arbiter side samples req and drives the grant.
  modport slave (input req, output gnt_valid, output gnt_id, output gnt);

endinterface

// File: rtl/rr_arbiter16_onehot_decoder.sv
// Combinational 4-to-16 decoder turning the registered grant index into a one-hot grant.
module onehot_decoder
  import rr_arbiter16_pkg::*;
(
  input  logic [IDX_W-1:0]   gnt_id,
  input  logic               gnt_valid,
  output logic [NUM_REQ-1:0] gnt
);

  // Decode the index and gate it so no bit is set while there is no grant.
  always_comb begin
    gnt = '0;
    if (gnt_valid) begin
      gnt[gnt_id] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Sixteen-way round-robin arbiter with a per-grant quantum limit under contention.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int QUANTUM = 4
)
(
  input logic          clk,
  input logic          rst_n,
  rr_arbiter16_if.slave bus
);

  localparam logic [3:0] QMAX = 4'(QUANTUM - 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   ptr;
  logic [3:0]         qcnt;
  logic [IDX_W-1:0]   cur_id;
  logic               valid;

  logic [NUM_REQ-1:0] cand;
  logic               others;
  logic               hit;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   win;

  // Rotating priority search from ptr; the current holder is masked out while granting.
  always_comb begin
    cand   = (state == GRANT) ? (bus.req & ~(16'b1 << cur_id)) : bus.req;
    others = |(bus.req & ~(16'b1 << cur_id));
    hit    = 1'b0;
    idx    = '0;
    win    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!hit && cand[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  // Arbitration FSM: new grants advance ptr past the winner and restart the quantum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      qcnt   <= '0;
      cur_id <= '0;
      valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state  <= GRANT;
            cur_id <= win;
            valid  <= 1'b1;
            ptr    <= win + 4'd1;
            qcnt   <= '0;
          end
        end
        GRANT: begin
          if (!bus.req[cur_id]) begin
            if (others) begin
              cur_id <= win;
              ptr    <= win + 4'd1;
              qcnt   <= '0;
            end else begin
              state <= IDLE;
              valid <= 1'b0;
              qcnt  <= '0;
            end
          end else if (others && qcnt == QMAX) begin
            cur_id <= win;
            ptr    <= win + 4'd1;
            qcnt   <= '0;
          end else if (others) begin
            qcnt <= qcnt + 4'd1;
          end else begin
            qcnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_valid = valid;
  assign bus.gnt_id    = cur_id;

  onehot_decoder u_decoder (
    .gnt_id    (cur_id),
    .gnt_valid (valid),
    .gnt       (bus.gnt)
  );

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16 against a behavioural round-robin model.
module tb_rr_arbiter16;

  localparam int Q = 4;

  logic clk;
  logic rst_n;

  rr_arbiter16_if bus ();

  rr_arbiter16 #(.QUANTUM(Q)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int tests_run;
  int tests_failed;

  // Reference model state: who holds, whether anyone holds, where the search starts,
  // and how many contended cycles the holder has already enjoyed.
  bit          m_valid;
  int          m_id;
  int          m_ptr;
  int          m_run;
  logic [15:0] m_gnt;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [15:0] q, input int from, input int excl);
    for (int j = 0; j < 16; j++) begin
      int k;
      k = (from + j) % 16;
      if (q[k] && k != excl) return k;
    end
    return -1;
  endfunction

  function automatic void give(input int w);
    m_valid = 1'b1;
    m_id    = w;
    m_ptr   = (w + 1) % 16;
    m_run   = 0;
  endfunction

  function automatic void model_update(input logic r, input logic [15:0] q);
    bit others;
    if (!r) begin
      m_valid = 1'b0;
      m_id    = 0;
      m_ptr   = 0;
      m_run   = 0;
    end else if (!m_valid) begin
      if (q != 16'h0) give(pick(q, m_ptr, -1));
    end else begin
      others = pick(q, m_ptr, m_id) >= 0;
      if (!q[m_id]) begin
        if (others) give(pick(q, m_ptr, m_id));
        else begin
          m_valid = 1'b0;
          m_run   = 0;
        end
      end else if (others && m_run + 1 >= Q) begin
        give(pick(q, m_ptr, m_id));
      end else if (others) begin
        m_run = m_run + 1;
      end else begin
        m_run = 0;
      end
    end
    m_gnt = m_valid ? (16'h0001 << m_id) : 16'h0000;
  endfunction

  task automatic step(input logic r, input logic [15:0] q);
    @(negedge clk);
    rst_n   = r;
    bus.req = q;
    @(posedge clk);
    model_update(r, q);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 16'h0000);
    step(1'b0, 16'h0000);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 16'hFFFF);
      tests_run++;
      if (bus.gnt_valid !== 1'b0 || bus.gnt !== 16'h0000 || bus.gnt_id !== 4'd0) begin
        tests_failed++;
        $display("[TB] FAIL reset_hold c%0d: valid=%b id=%0d gnt=%h, expected valid=0 id=0 gnt=0000",
                 c, bus.gnt_valid, bus.gnt_id, bus.gnt);
      end
    end
    step(1'b1, 16'hFFFF);
    tests_run++;
    if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 4'd0 || bus.gnt !== 16'h0001) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_grant: valid=%b id=%0d gnt=%h, expected valid=1 id=0 gnt=0001",
               bus.gnt_valid, bus.gnt_id, bus.gnt);
    end
    step(1'b1, 16'h0006);
    tests_run++;
    if (bus.gnt_id !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL reset_ptr_is_1: id=%0d, expected 1", bus.gnt_id);
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 16'h0020);
      tests_run++;
      if (bus.gnt_valid !== 1'b1 || bus.gnt !== 16'h0020 || bus.gnt_id !== 4'd5) begin
        tests_failed++;
        $display("[TB] FAIL single_hold c%0d: valid=%b id=%0d gnt=%h, expected valid=1 id=5 gnt=0020",
                 c, bus.gnt_valid, bus.gnt_id, bus.gnt);
      end
    end
    step(1'b1, 16'h0000);
    tests_run++;
    if (bus.gnt_valid !== 1'b0 || bus.gnt !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL single_drop: valid=%b gnt=%h, expected valid=0 gnt=0000",
               bus.gnt_valid, bus.gnt);
    end
  endtask

  task automatic test_two_way();
    int exp_id;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      step(1'b1, 16'h0009);
      exp_id = ((k / Q) % 2 == 0) ? 0 : 3;
      tests_run++;
      if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 4'(exp_id) || bus.gnt !== (16'h0001 << exp_id)) begin
        tests_failed++;
        $display("[TB] FAIL two_way k%0d: valid=%b id=%0d gnt=%h, expected valid=1 id=%0d",
                 k, bus.gnt_valid, bus.gnt_id, bus.gnt, exp_id);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b1, 16'h8000);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 16'h8002);
      tests_run++;
      if (bus.gnt_valid !== m_valid || bus.gnt !== m_gnt || (m_valid && bus.gnt_id !== 4'(m_id))) begin
        tests_failed++;
        $display("[TB] FAIL wrap k%0d: valid=%b id=%0d gnt=%h, expected valid=%b id=%0d gnt=%h",
                 k, bus.gnt_valid, bus.gnt_id, bus.gnt, m_valid, m_id, m_gnt);
      end
    end
    tests_run++;
    if (bus.gnt_id !== 4'd15) begin
      tests_failed++;
      $display("[TB] FAIL wrap_cycle: id=%0d, expected 15", bus.gnt_id);
    end
  endtask

  task automatic test_handoff();
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 16'h0004);
    step(1'b1, 16'h0080);
    tests_run++;
    if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 4'd7 || bus.gnt !== 16'h0080) begin
      tests_failed++;
      $display("[TB] FAIL handoff: valid=%b id=%0d gnt=%h, expected valid=1 id=7 gnt=0080",
               bus.gnt_valid, bus.gnt_id, bus.gnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 16'h0200);
    step(1'b1, 16'h0200);
    tests_run++;
    if (bus.gnt_id !== 4'd9 || bus.gnt_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_pre: valid=%b id=%0d, expected valid=1 id=9",
               bus.gnt_valid, bus.gnt_id);
    end
    step(1'b0, 16'hFFFF);
    tests_run++;
    if (bus.gnt !== 16'h0000 || bus.gnt_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_clear: valid=%b gnt=%h, expected valid=0 gnt=0000",
               bus.gnt_valid, bus.gnt);
    end
    step(1'b1, 16'hFFFF);
    tests_run++;
    if (bus.gnt_id !== 4'd0 || bus.gnt !== 16'h0001) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_restart: id=%0d gnt=%h, expected id=0 gnt=0001",
               bus.gnt_id, bus.gnt);
    end
  endtask

  task automatic test_random();
    logic [15:0] q;
    logic        r;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 3))
        0:       q = 16'($urandom) & 16'($urandom) & 16'($urandom);
        1:       q = 16'($urandom) & 16'($urandom);
        2:       q = 16'h0001 << $urandom_range(0, 15);
        default: q = (k % 7 == 0) ? 16'h0000 : bus.req;
      endcase
      r = ($urandom_range(0, 63) != 0);
      step(r, q);
      tests_run++;
      if (bus.gnt_valid !== m_valid || bus.gnt !== m_gnt || (m_valid && bus.gnt_id !== 4'(m_id))) begin
        tests_failed++;
        $display("[TB] FAIL random k%0d req=%h rst_n=%b: valid=%b id=%0d gnt=%h, expected valid=%b id=%0d gnt=%h",
                 k, q, r, bus.gnt_valid, bus.gnt_id, bus.gnt, m_valid, m_id, m_gnt);
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.req      = 16'h0000;
    m_valid      = 1'b0;
    m_id         = 0;
    m_ptr        = 0;
    m_run        = 0;
    m_gnt        = 16'h0000;
    test_reset();
    test_single();
    test_two_way();
    test_wrap();
    test_handoff();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
